bus_ram_io_timer: RTL and testbench
===================================

Name: bus_ram_io_timer

Overview:
- Memory/IO peripheral sitting directly downstream of the CPU top on the multiplexed 8085 bus. It consumes ALE, RDn, WRn, IOMn and the AD[7:0] bus.
- Demultiplexes and latches the low address. Provides a 256x8 RAM in memory space and, in IO space, a command/status register, two 8-bit parallel ports and a 14-bit down-counting timer.
- The tri-state is resolved by the top level; this block exposes split in/out/enable data.

Parameters:
- TIMER_W, 14, timer counter width. The high-length register holds bits [TIMER_W-1:8].
- RAM_DEPTH, 256, RAM bytes. Addressed by the latched AD[7:0]; fixed at 256 in this revision.

Ports:
- clk  input  1  system clock (CPU clk_out); all logic on the rising edge
- resetn_in  input  1  asynchronous, active-low reset
- ce  input  1  chip enable from external high-address decode; sampled with ALE
- ale  input  1  address latch enable
- iomn  input  1  1 = IO cycle, 0 = memory cycle; sampled with ALE
- rdn  input  1  read strobe, active low
- wrn  input  1  write strobe, active low
- ad_in  input  8  multiplexed address/data from the pins
- ad_out  output  8  read data
- ad_oe  output  1  drive enable for ad_out onto the AD pins
- pa_in, pb_in  input  8 each  port pin inputs
- pa_out, pb_out  output  8 each  port output latches
- pa_oe, pb_oe  output  1 each  port direction (1 = output)
- timer_in  input  1  asynchronous count source
- timer_out  output  1  one-clk pulse at terminal count

Behaviour:
- Reset:
  - All registers are 0: address latch, cmd, pa_out, pb_out, timer length, counter, running, tc_flag.
  - pa_oe = pb_oe = 0; ad_oe = 0; timer_out = 0.
  - RAM contents are not reset.
- Address phase: on a clk edge with ale = 1, latch addr_q <= ad_in, io_q <= iomn, sel_q <= ce. The latch holds until the next ALE.
- Read:
  - ad_oe = sel_q & ~rdn, combinational.
  - ad_out is a combinational mux on addr_q / io_q, so data is valid in the same cycle rdn falls.
- Write:
  - Registered rdn_q/wrn_q strobe history is kept.
  - A write commits at the clk edge where wrn = 0 and wrn_q = 1, using ad_in at that edge. Exactly one commit occurs per WR strobe.
  - Writes with sel_q = 0 are ignored.
- Memory space (io_q = 0): RAM[addr_q].
- IO space (io_q = 1), decoded on addr_q[2:0]:
  - 0 command (W): bit0 = pa_oe, bit1 = pb_oe, bits7:6 = timer command: 00 nop, 01 stop now, 10 stop after next TC, 11 start/load.
  - 0 status (R): bit7 = running, bit6 = tc_flag, bits1:0 = pb_oe, pa_oe, other bits 0. A completed status read (rdn rising edge, sel_q = 1) clears tc_flag.
  - 1 port A: write sets pa_out. Read returns pa_out if pa_oe = 1, else pa_in.
  - 2 port B: same as port A, using the pb_* signals.
  - 4 timer length low byte (R/W).
  - 5 bits5:0 = length high bits, bit6 = auto-reload, bit7 reads 0.
  - Addresses 3, 6 and 7 read 0x00; writes to them are ignored.
- Timer source:
  - timer_in passes through a 2-flop synchroniser plus edge detect.
  - One count event occurs per synchronised rising edge.
- Timer start/load (cmd 11):
  - Counter <= length, running = 1.
  - A length of 0 or 1 is treated as 2.
  - Start while already running reloads the counter immediately.
- Timer count:
  - While running, each count event decrements the counter.
  - An event with counter == 1 is terminal count (TC):
    - timer_out pulses high for 1 clk;
    - tc_flag is set;
    - if auto-reload = 1 and no pending stop, counter <= length;
    - otherwise running = 0 and counter = 0.
- Timer stop:
  - cmd 01 clears running at the commit edge; no TC is generated.
  - cmd 10 sets pending_stop, which is cleared on the next TC.
  - A command with no timer running has no effect, except 11.
- Simultaneous events:
  - A command commit and TC on the same edge: the command wins for counter and running, but tc_flag is still set and timer_out still pulses.
  - Status-read clear and TC set on the same edge: set wins.
- Reset mid-cycle: all state is aborted immediately. The first bus cycle after release requires a new ALE before any access.

Test Plan:
- Memory write/read:
  - Stimulus: ALE cycle with ad_in = 0x3C, iomn = 0, ce = 1; WR strobe with data 0xA5; new ALE to 0x3C; RD strobe.
  - Required: ad_out = 0xA5 with ad_oe = 1 only while rdn = 0. The same sequence with ce = 0 leaves RAM unchanged and ad_oe = 0.
- Ports:
  - Stimulus: write cmd 0x01; write port A 0x5A; read port A; read port B with pb_in = 0xC3.
  - Required: pa_oe = 1, pa_out = 0x5A, port A read = 0x5A, port B read = 0xC3, pb_oe = 0.
- Single-shot timer:
  - Stimulus: length = 3, auto-reload = 0, cmd 0xC0; apply 3 timer_in rising edges.
  - Required: exactly one timer_out pulse, 2-3 clk after the 3rd edge. Status reads 0x40 (running = 0); a second status read returns 0x00.
- Auto-reload with pending stop:
  - Stimulus: length = 2, auto-reload = 1, start; 4 edges; then cmd 0x80; 2 more edges.
  - Required: 3 pulses total, then running = 0.
- Boundaries:
  - Stimulus: length = 0, start.
  - Required: TC after 2 edges. A stop cmd (0x40) mid-count gives no pulse and running = 0.
  - Stimulus: assert resetn_in low mid-WR strobe.
  - Required: no write commits and all outputs return to their reset values.

Source files
------------

// File: rtl/bus_ram_io_timer.sv
// 8085-bus peripheral: latched low address, 256x8 RAM in memory space, and
// in IO space a command/status register, two parallel ports and a down-counting timer.
module bus_ram_io_timer #(
  parameter int TIMER_W   = 14,
  parameter int RAM_DEPTH = 256
) (
  input  logic       clk,
  input  logic       resetn_in,
  input  logic       ce,
  input  logic       ale,
  input  logic       iomn,
  input  logic       rdn,
  input  logic       wrn,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic [7:0] pa_in,
  input  logic [7:0] pb_in,
  output logic [7:0] pa_out,
  output logic [7:0] pb_out,
  output logic       pa_oe,
  output logic       pb_oe,
  input  logic       timer_in,
  output logic       timer_out
);

  localparam int HI_W = TIMER_W - 8;

  // Bus handshake: reads are combinational while sel_q & ~rdn; a write commits
  // once, on the first clk edge that sees wrn low after it was sampled high.
  logic [7:0]         r_addr;
  logic               r_io;
  logic               r_sel;
  logic               r_rdn_q;
  logic               r_wrn_q;
  logic [7:0]         r_mem [0:RAM_DEPTH-1];
  logic               r_pa_oe;
  logic               r_pb_oe;
  logic [7:0]         r_pa_out;
  logic [7:0]         r_pb_out;
  logic [TIMER_W-1:0] r_len;
  logic               r_auto;
  logic [TIMER_W-1:0] r_cnt;
  logic               r_running;
  logic               r_pend;
  logic               r_tc_flag;
  logic               r_tout;
  logic [1:0]         r_tsync;
  logic               r_tin_q;

  logic               w_wr;
  logic               w_io_wr;
  logic               w_cmd_wr;
  logic               w_start;
  logic               w_stop;
  logic               w_stop_tc;
  logic               w_evt;
  logic               w_tc;
  logic               w_rd_done;
  logic [TIMER_W-1:0] w_len_eff;
  logic [7:0]         w_status;
  logic [7:0]         w_len_hi_rd;
  logic [7:0]         w_rd_data;

  always_comb begin
    w_wr      = r_sel & ~wrn & r_wrn_q;
    w_io_wr   = w_wr & r_io;
    w_cmd_wr  = w_io_wr & (r_addr[2:0] == 3'd0);
    w_start   = w_cmd_wr & (ad_in[7:6] == 2'b11);
    w_stop    = w_cmd_wr & (ad_in[7:6] == 2'b01) & r_running;
    w_stop_tc = w_cmd_wr & (ad_in[7:6] == 2'b10) & r_running;
    w_evt     = r_tsync[1] & ~r_tin_q;
    w_tc      = r_running & w_evt & (r_cnt == TIMER_W'(1));
    w_rd_done = r_sel & r_io & (r_addr[2:0] == 3'd0) & rdn & ~r_rdn_q;
    w_len_eff = (r_len < TIMER_W'(2)) ? TIMER_W'(2) : r_len;
  end

  always_ff @(posedge clk or negedge resetn_in) begin
    if (!resetn_in) begin
      r_addr  <= '0;
      r_io    <= 1'b0;
      r_sel   <= 1'b0;
      r_rdn_q <= 1'b0;
      r_wrn_q <= 1'b0;
    end else begin
      r_rdn_q <= rdn;
      r_wrn_q <= wrn;
      if (ale) begin
        r_addr <= ad_in;
        r_io   <= iomn;
        r_sel  <= ce;
      end
    end
  end

  // RAM contents survive reset; commits are already gated by sel_q.
  always_ff @(posedge clk) begin
    if (w_wr && !r_io) r_mem[r_addr] <= ad_in;
  end

  always_ff @(posedge clk or negedge resetn_in) begin
    if (!resetn_in) begin
      r_pa_oe  <= 1'b0;
      r_pb_oe  <= 1'b0;
      r_pa_out <= '0;
      r_pb_out <= '0;
      r_len    <= '0;
      r_auto   <= 1'b0;
    end else if (w_io_wr) begin
      case (r_addr[2:0])
        3'd0: {r_pb_oe, r_pa_oe} <= ad_in[1:0];
        3'd1: r_pa_out <= ad_in;
        3'd2: r_pb_out <= ad_in;
        3'd4: r_len[7:0] <= ad_in;
        3'd5: begin
          r_len[TIMER_W-1:8] <= ad_in[HI_W-1:0];
          r_auto             <= ad_in[6];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn_in) begin
    if (!resetn_in) begin
      r_tsync <= '0;
      r_tin_q <= 1'b0;
    end else begin
      r_tsync <= {r_tsync[0], timer_in};
      r_tin_q <= r_tsync[1];
    end
  end

  // A command on the TC edge owns counter/running; TC still flags and pulses.
  always_ff @(posedge clk or negedge resetn_in) begin
    if (!resetn_in) begin
      r_cnt     <= '0;
      r_running <= 1'b0;
      r_pend    <= 1'b0;
      r_tc_flag <= 1'b0;
      r_tout    <= 1'b0;
    end else begin
      r_tout <= w_tc;
      if (w_tc) r_tc_flag <= 1'b1;
      else if (w_rd_done) r_tc_flag <= 1'b0;

      if (w_start) begin
        r_cnt     <= w_len_eff;
        r_running <= 1'b1;
        r_pend    <= 1'b0;
      end else if (w_stop) begin
        r_cnt     <= '0;
        r_running <= 1'b0;
        r_pend    <= 1'b0;
      end else if (w_tc) begin
        if (r_auto && !r_pend && !w_stop_tc) begin
          r_cnt <= w_len_eff;
        end else begin
          r_cnt     <= '0;
          r_running <= 1'b0;
        end
        r_pend <= 1'b0;
      end else begin
        if (w_evt && r_running) r_cnt <= r_cnt - TIMER_W'(1);
        if (w_stop_tc) r_pend <= 1'b1;
      end
    end
  end

  always_comb begin
    w_status    = {r_running, r_tc_flag, 4'b0000, r_pb_oe, r_pa_oe};
    w_len_hi_rd = '0;
    w_len_hi_rd[HI_W-1:0] = r_len[TIMER_W-1:8];
    w_len_hi_rd[6] = r_auto;
    w_rd_data = '0;
    if (!r_io) begin
      w_rd_data = r_mem[r_addr];
    end else begin
      case (r_addr[2:0])
        3'd0:    w_rd_data = w_status;
        3'd1:    w_rd_data = r_pa_oe ? r_pa_out : pa_in;
        3'd2:    w_rd_data = r_pb_oe ? r_pb_out : pb_in;
        3'd4:    w_rd_data = r_len[7:0];
        3'd5:    w_rd_data = w_len_hi_rd;
        default: w_rd_data = '0;
      endcase
    end
  end

  assign ad_oe     = r_sel & ~rdn;
  assign ad_out    = ad_oe ? w_rd_data : 8'h00;
  assign pa_out    = r_pa_out;
  assign pb_out    = r_pb_out;
  assign pa_oe     = r_pa_oe;
  assign pb_oe     = r_pb_oe;
  assign timer_out = r_tout;

endmodule

// File: tb/tb_bus_ram_io_timer.sv
// Directed bench for bus_ram_io_timer: bus cycles driven on the falling clk
// edge, outputs sampled away from the rising edge, immediate-assert checks.
module tb_bus_ram_io_timer;

  logic       clk;
  logic       resetn_in;
  logic       ce;
  logic       ale;
  logic       iomn;
  logic       rdn;
  logic       wrn;
  logic [7:0] ad_in;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic [7:0] pa_in;
  logic [7:0] pb_in;
  logic [7:0] pa_out;
  logic [7:0] pb_out;
  logic       pa_oe;
  logic       pb_oe;
  logic       timer_in;
  logic       timer_out;

  int n_assert = 0;
  int n_fail   = 0;

  bus_ram_io_timer #(.TIMER_W(14), .RAM_DEPTH(256)) dut (
    .clk(clk), .resetn_in(resetn_in), .ce(ce), .ale(ale), .iomn(iomn),
    .rdn(rdn), .wrn(wrn), .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe),
    .pa_in(pa_in), .pb_in(pb_in), .pa_out(pa_out), .pb_out(pb_out),
    .pa_oe(pa_oe), .pb_oe(pb_oe), .timer_in(timer_in), .timer_out(timer_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_addr(input logic io, input logic c, input logic [7:0] a);
    @(negedge clk);
    ale = 1'b1; iomn = io; ce = c; ad_in = a;
    @(negedge clk);
    ale = 1'b0; ad_in = 8'h00;
  endtask

  // wrn is held low for two edges with changed data to expose double commits.
  task automatic bus_write(input logic [7:0] d);
    @(negedge clk);
    wrn = 1'b0; ad_in = d;
    @(negedge clk);
    ad_in = ~d;
    @(negedge clk);
    wrn = 1'b1; ad_in = 8'h00;
    @(negedge clk);
  endtask

  task automatic bus_read(output logic [7:0] d, output logic oe_pre,
                          output logic oe_in, output logic oe_post);
    @(negedge clk);
    oe_pre = ad_oe;
    rdn = 1'b0;
    #1;
    d = ad_out; oe_in = ad_oe;
    @(negedge clk);
    rdn = 1'b1;
    #1;
    oe_post = ad_oe;
    @(negedge clk);
  endtask

  task automatic io_wr(input logic [7:0] a, input logic [7:0] d);
    bus_addr(1'b1, 1'b1, a);
    bus_write(d);
  endtask

  task automatic io_rd(input logic [7:0] a, output logic [7:0] d);
    logic o1, o2, o3;
    bus_addr(1'b1, 1'b1, a);
    bus_read(d, o1, o2, o3);
  endtask

  // One timer_in pulse in a fixed 6-cycle window; reports pulses seen and latency.
  task automatic tin_edge(output int pulses, output int lat);
    pulses = 0; lat = -1;
    @(negedge clk);
    timer_in = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (timer_out) begin
        pulses++;
        if (lat < 0) lat = i;
      end
      if (i == 3) timer_in = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] d;
    logic       o_pre, o_in, o_post;
    int         p, lat, tot;

    resetn_in = 1'b0; ce = 1'b0; ale = 1'b0; iomn = 1'b0;
    rdn = 1'b1; wrn = 1'b1; ad_in = 8'h00;
    pa_in = 8'h0F; pb_in = 8'hC3; timer_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ad_oe", 16'(ad_oe), 16'h0);
    chk("rst_pa_out", 16'(pa_out), 16'h0);
    chk("rst_pb_out", 16'(pb_out), 16'h0);
    chk("rst_oe", 16'({pb_oe, pa_oe}), 16'h0);
    chk("rst_timer_out", 16'(timer_out), 16'h0);
    resetn_in = 1'b1;
    repeat (2) @(negedge clk);
    io_rd(8'h00, d);
    chk("rst_status", 16'(d), 16'h00);

    // Memory write then read back
    bus_addr(1'b0, 1'b1, 8'h3C);
    bus_write(8'hA5);
    bus_addr(1'b0, 1'b1, 8'h3C);
    bus_read(d, o_pre, o_in, o_post);
    chk("mem_rd_data", 16'(d), 16'hA5);
    chk("mem_oe_pre", 16'(o_pre), 16'h0);
    chk("mem_oe_in", 16'(o_in), 16'h1);
    chk("mem_oe_post", 16'(o_post), 16'h0);

    // Deselected write and read
    bus_addr(1'b0, 1'b0, 8'h3C);
    bus_write(8'h5B);
    bus_addr(1'b0, 1'b0, 8'h3C);
    bus_read(d, o_pre, o_in, o_post);
    chk("nosel_oe", 16'(o_in), 16'h0);
    bus_addr(1'b0, 1'b1, 8'h3C);
    bus_read(d, o_pre, o_in, o_post);
    chk("nosel_ram_kept", 16'(d), 16'hA5);

    // Ports
    io_wr(8'h00, 8'h01);
    chk("port_pa_oe", 16'(pa_oe), 16'h1);
    chk("port_pb_oe", 16'(pb_oe), 16'h0);
    io_wr(8'h01, 8'h5A);
    chk("port_pa_out", 16'(pa_out), 16'h5A);
    io_rd(8'h01, d);
    chk("port_a_rd", 16'(d), 16'h5A);
    io_rd(8'h02, d);
    chk("port_b_rd", 16'(d), 16'hC3);

    // Length registers and unused addresses
    io_wr(8'h04, 8'h34);
    io_wr(8'h05, 8'hFF);
    io_rd(8'h05, d);
    chk("len_hi_rd", 16'(d), 16'h7F);
    io_rd(8'h04, d);
    chk("len_lo_rd", 16'(d), 16'h34);
    io_wr(8'h03, 8'h55);
    io_rd(8'h03, d);
    chk("addr3_rd", 16'(d), 16'h00);

    // Single-shot timer, length 3
    io_wr(8'h04, 8'h03);
    io_wr(8'h05, 8'h00);
    io_wr(8'h00, 8'hC0);
    io_rd(8'h00, d);
    chk("ss_running", 16'(d), 16'h80);
    io_rd(8'h01, d);
    chk("ss_pa_in_rd", 16'(d), 16'h0F);
    tot = 0;
    tin_edge(p, lat); tot += p;
    tin_edge(p, lat); tot += p;
    chk("ss_no_early_pulse", 16'(tot), 16'd0);
    tin_edge(p, lat);
    chk("ss_one_pulse", 16'(p), 16'd1);
    chk("ss_latency", 16'(lat), 16'd3);
    io_rd(8'h00, d);
    chk("ss_status_tc", 16'(d), 16'h40);
    io_rd(8'h00, d);
    chk("ss_status_clr", 16'(d), 16'h00);

    // Auto-reload, then stop-after-next-TC
    io_wr(8'h04, 8'h02);
    io_wr(8'h05, 8'h40);
    io_wr(8'h00, 8'hC0);
    tot = 0;
    for (int i = 0; i < 4; i++) begin
      tin_edge(p, lat); tot += p;
    end
    chk("ar_two_pulses", 16'(tot), 16'd2);
    io_rd(8'h00, d);
    chk("ar_status_run", 16'(d), 16'hC0);
    io_wr(8'h00, 8'h80);
    tin_edge(p, lat); tot += p;
    tin_edge(p, lat); tot += p;
    chk("ar_three_pulses", 16'(tot), 16'd3);
    io_rd(8'h00, d);
    chk("ar_stopped", 16'(d), 16'h40);

    // Length 0 behaves as 2
    io_wr(8'h04, 8'h00);
    io_wr(8'h05, 8'h00);
    io_wr(8'h00, 8'hC0);
    tin_edge(p, lat);
    chk("len0_edge1", 16'(p), 16'd0);
    tin_edge(p, lat);
    chk("len0_edge2", 16'(p), 16'd1);
    io_rd(8'h00, d);
    chk("len0_status", 16'(d), 16'h40);

    // Immediate stop mid-count
    io_wr(8'h00, 8'hC0);
    tin_edge(p, lat);
    tot = p;
    io_wr(8'h00, 8'h40);
    io_rd(8'h00, d);
    chk("stop_status", 16'(d), 16'h00);
    tin_edge(p, lat); tot += p;
    tin_edge(p, lat); tot += p;
    chk("stop_no_pulse", 16'(tot), 16'd0);

    // Reset asserted mid-WR strobe
    io_wr(8'h00, 8'h03);
    io_wr(8'h01, 8'h77);
    bus_addr(1'b0, 1'b1, 8'h10);
    bus_write(8'h11);
    bus_addr(1'b0, 1'b1, 8'h10);
    @(negedge clk);
    wrn = 1'b0; ad_in = 8'h99;
    #2 resetn_in = 1'b0;
    #1;
    chk("mrst_pa_out", 16'(pa_out), 16'h0);
    chk("mrst_oe", 16'({pb_oe, pa_oe}), 16'h0);
    chk("mrst_ad_oe", 16'(ad_oe), 16'h0);
    chk("mrst_timer_out", 16'(timer_out), 16'h0);
    @(negedge clk);
    @(negedge clk);
    wrn = 1'b1; ad_in = 8'h00; resetn_in = 1'b1;
    @(negedge clk);
    bus_addr(1'b0, 1'b1, 8'h10);
    bus_read(d, o_pre, o_in, o_post);
    chk("mrst_ram_kept", 16'(d), 16'h11);
    io_rd(8'h00, d);
    chk("mrst_status", 16'(d), 16'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
